// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the CPU load/store port: one request at a time,
// fixed LATENCY from accept to ack. Define DMEM_RESP_ERR_EN for address checking.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic          err;
    } req_t;

    state_t        state;
    logic [CW-1:0] cnt;
    req_t          cur;
    req_t          nxt_req;
    logic          addr_err;
    logic          accept;
    logic          done;
    logic [31:0]   mem [DEPTH];

`ifdef DMEM_RESP_ERR_EN
    assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(DEPTH * 4));
`else
    // Misaligned/out-of-range addresses simply wrap onto the word array.
    logic unused_addr;
    assign addr_err    = 1'b0;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    assign nxt_req = '{we: we_i, idx: addr_i[AW+1:2], wdata: wdata_i, err: addr_err};

    // The edge closing the ack cycle can already take the next request.
    assign accept = req_i && (state == IDLE || state == RESP);
    assign done   = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur     <= '0;
            busy_o  <= 1'b0;
            ack_o   <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (accept) begin
                cur    <= nxt_req;
                cnt    <= CW'(LATENCY - 1);
                busy_o <= 1'b1;
                state  <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == '0) begin
                            state <= RESP;
                            ack_o <= 1'b1;
                            err_o <= cur.err;
                            if (!cur.we)
                                rdata_o <= cur.err ? 32'h0 : mem[cur.idx];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    RESP: begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Store commit shares the completion edge with load sampling.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (done && cur.we && !cur.err) begin
            mem[cur.idx] <= cur.wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the directed
// sequences and a LATENCY=3 instance for back-to-back held requests.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, we, req2, we2;
    logic [31:0] addr, wdata, addr2, wdata2;
    logic        busy, ack, err, busy2, ack2, err2;
    logic [31:0] rdata, rdata2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int prev_ack2 = -1;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mdl [32];
    logic [31:0] last_rd = '0;
    logic [31:0] mdl2_w0 = '0;
    logic [31:0] last_rd2 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(32), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .busy_o(busy), .ack_o(ack), .rdata_o(rdata), .err_o(err)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_n(rst_n), .req_i(req2), .we_i(we2), .addr_i(addr2),
        .wdata_i(wdata2), .busy_o(busy2), .ack_o(ack2), .rdata_o(rdata2), .err_o(err2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
        return (a[1:0] != 2'b00) || (a >= 32'd128);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        last_rd = '0;
    endfunction

    // Expected ack contents for the LATENCY=2 instance, model updated in order.
    function automatic void push1(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t       e;
        logic       bad;
        logic [4:0] idx;
        bad = addr_bad(a);
        idx = a[6:2];
        if (w) begin
            if (!bad) mdl[idx] = d;
        end else begin
            last_rd = bad ? 32'h0 : mdl[idx];
        end
        e.rdata = last_rd;
        e.err   = bad;
        q1.push_back(e);
    endfunction

    function automatic void push2(input logic w, input logic [31:0] d);
        exp_t e;
        if (w) mdl2_w0 = d;
        else   last_rd2 = mdl2_w0;
        e.rdata = last_rd2;
        e.err   = 1'b0;
        q2.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (ack) begin
            if (q1.size() == 0) chk("spurious_ack", 32'(ack), 32'd0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("err", 32'(err), 32'(e.err));
            end
        end
        if (ack2) begin
            if (q2.size() == 0) chk("spurious_ack2", 32'(ack2), 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("rdata2", rdata2, e.rdata);
                chk("err2", 32'(err2), 32'(e.err));
            end
            if (prev_ack2 >= 0) chk("ack2_gap", 32'(cyc - prev_ack2), 32'd4);
            prev_ack2 = cyc;
        end
    end

    // One full transaction on the LATENCY=2 instance with busy/ack timing checks;
    // inject drives a store to 0x0C on the edge after accept, which must be dropped.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit inject);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        push1(w, a, d);
        #1;
        chk("busy_n0", 32'(busy), 32'd1);
        chk("ack_n0", 32'(ack), 32'd0);
        @(negedge clk);
        req = 1'b0;
        if (inject) begin
            req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h1;
        end
        @(posedge clk); #1;
        chk("busy_n1", 32'(busy), 32'd1);
        chk("ack_n1", 32'(ack), 32'd0);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk("busy_n2", 32'(busy), 32'd1);
        chk("ack_n2", 32'(ack), 32'd1);
        @(posedge clk); #1;
        chk("busy_n3", 32'(busy), 32'd0);
        chk("ack_n3", 32'(ack), 32'd0);
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        clear_model();

        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_busy2", 32'(busy2), 32'd0);
        end
        rst_n = 1'b1;

        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h08, 32'h0, 1'b0);

        do_req(1'b1, 32'h14, 32'h12345678, 1'b1);
        do_req(1'b0, 32'h0C, 32'h0, 1'b0);
        do_req(1'b0, 32'h14, 32'h0, 1'b0);

        // Abort a store with reset one cycle after accept.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_req(1'b0, 32'h04, 32'h0, 1'b0);
        do_req(1'b0, 32'h08, 32'h0, 1'b0);

        do_req(1'b1, 32'h00, 32'hCAFE0000, 1'b0);
        do_req(1'b0, 32'h82, 32'h0, 1'b0);
        do_req(1'b1, 32'h80, 32'h7, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 1'b0);
        do_req(1'b1, 32'h7C, 32'hA5A55A5A, 1'b0);
        do_req(1'b0, 32'h7C, 32'h0, 1'b0);

        // Held request on the LATENCY=3 instance, alternating store/load to 0x00.
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0; wdata2 = $urandom;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            push2(we2, wdata2);
            #1;
            chk("busy2_acc", 32'(busy2), 32'd1);
            @(negedge clk);
            if (t < 5) begin
                we2 = ~we2;
                wdata2 = $urandom;
            end else begin
                req2 = 1'b0;
            end
            repeat (3) @(posedge clk);
        end
        @(posedge clk); #1;
        chk("busy2_end", 32'(busy2), 32'd0);

        repeat (4) @(posedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
